ssb_re_extractor: RTL
=====================

Name: ssb_re_extractor

Overview:
- Sits after FFT_demod. Takes its per-bin demodulated stream plus the SSS and PBCH symbol qualifiers.
- Maps each bin to its SSB resource-element role:
  - SSS bins go out as 1-bit BPSK hard decisions to SSS_detector.
  - PBCH bins (full PBCH symbols plus both PBCH edges of the SSS symbol) go out as saturated soft LLR pairs through a backpressured FIFO to the channel estimator / PBCH decoder.
- Generalises the fixed SSS-only extraction counter: parametrised FFT size, SSB placement, LLR width and buffering.

Parameters:
- IN_DW, 32, complex input width; real = [IN_DW/2-1:0], imag = upper half
- NFFT, 8, log2 FFT size; bins per symbol = 2**NFFT
- SSB_START, 8, FFT bin index of SSB subcarrier 0; SSB_START+240 <= 2**NFFT
- LLR_DW, 8, bits per soft component; 2 <= LLR_DW <= IN_DW/2
- FIFO_DEPTH, 16, PBCH output FIFO entries, power of 2

Ports:
- clk_i  in  1  clock
- reset_ni  in  1  asynchronous active-low reset
- s_axis_in_tdata  in  IN_DW  FFT bin sample
- s_axis_in_tvalid  in  1  sample valid
- SSS_valid_i  in  1  current sample belongs to SSS symbol
- PBCH_valid_i  in  1  current sample belongs to a PBCH-only symbol
- m_axis_SSS_tdata  out  1  hard bit, 1 when real >= 0
- m_axis_SSS_tvalid  out  1  SSS bit valid
- SSS_done_o  out  1  pulse after 127th SSS bit
- m_axis_PBCH_tdata  out  2*LLR_DW  {llr_im, llr_re}
- m_axis_PBCH_tvalid  out  1  FIFO not empty
- m_axis_PBCH_tready  in  1  consumer ready
- PBCH_done_o  out  1  pulse when 576th PBCH RE of an SSB is processed
- overflow_o  out  1  sticky: PBCH RE dropped on full FIFO
- protocol_err_o  out  1  sticky: SSS_valid_i and PBCH_valid_i high together

Behaviour:
- Async reset clears all state. Every output is 0 after reset; the FIFO is empty.
- A sample is accepted when s_axis_in_tvalid & (SSS_valid_i | PBCH_valid_i).
- bin_cnt (NFFT bits) counts accepted samples within a symbol. A symbol ends after bin 2**NFFT-1, or when both qualifiers are low for a valid sample. Either condition returns bin_cnt to 0.
- State machine:
  - IDLE: first accepted sample enters SSS_SYM or PBCH_SYM according to its qualifier.
  - SSS_SYM / PBCH_SYM: process bins; on last bin, go to IDLE.
  - A qualifier change mid-symbol restarts bin_cnt at 0 in the new symbol state.
- Simultaneous qualifiers: the sample is treated as SSS and protocol_err_o is set.
- Let k = bin_cnt - SSB_START. Mapping for SSS_SYM:
  - k in 56..182: SSS bit.
  - k in 0..47 or 192..239: PBCH RE.
  - Otherwise: discarded.
- Mapping for PBCH_SYM: k in 0..239 is a PBCH RE.
- SSS output: registered, 1-cycle latency, no backpressure. SSS_done_o pulses the cycle after the 127th bit's tvalid. The SSS bit counter resets at each SSS_SYM entry.
- LLR per component: arithmetic right shift by IN_DW/2-LLR_DW (truncate), then saturate to [-(2**(LLR_DW-1)-1), 2**(LLR_DW-1)-1]. The most negative code is never emitted.
- FIFO push on a PBCH RE:
  - If full and not popping in the same cycle: drop the RE and set overflow_o.
  - Push and pop in the same cycle are both legal, including when full.
  - tdata/tvalid are registered; a pushed word is visible 1 cycle after the push.
- pbch_re_cnt (0..575) counts PBCH REs processed, whether accepted or dropped. When it reaches 575, PBCH_done_o pulses next cycle and the counter wraps to 0.
- Sticky flags clear only on reset.

Decomposition:
- Package ssb_pkg holds:
  - SSB_LEN = 240, SSS_OFFSET = 56, SSS_LEN = 127, PBCH_EDGE_LEN = 48, PBCH_RE_PER_SSB = 576
  - state enum {IDLE, SSS_SYM, PBCH_SYM}
- One sub-module: axis_fifo (sync, parameters DW and DEPTH, registered output, async active-low reset), reusable elsewhere.

Test Plan:
- NFFT=8, SSB_START=8:
  - Stimulus: one SSS symbol of 256 valid samples, real = +1000 on even bins, -1000 on odd bins, tready=1.
  - Required: exactly 127 SSS bits on bins 64..190; first bit 1 (bin 64 even); alternating; SSS_done_o 1 cycle after the last bit; 96 PBCH words.
- PBCH symbol, SSS symbol, PBCH symbol, tready=1:
  - Required: 576 PBCH words, PBCH_done_o pulses once, overflow_o stays 0.
- LLR saturation, IN_DW=32, LLR_DW=8:
  - real = 0x7FFF gives llr_re = 127.
  - real = 0x8000 gives llr_re = -127.
  - real = 0x0100 gives llr_re = 1.
- Backpressure, tready=0 through one full PBCH symbol, FIFO_DEPTH=16:
  - Required: 16 words held, overflow_o = 1, PBCH_done_o still fires on the SSB's 576th RE.
  - Then tready=1 drains exactly 16 words in order.
- Reset mid-SSS symbol:
  - Assert reset_ni=0 after 100 bins without a clock edge.
  - Required: outputs 0 immediately; after release, a fresh SSS symbol yields exactly 127 bits.
- SSS_valid_i and PBCH_valid_i both high on one sample:
  - Required: protocol_err_o = 1 and the sample is handled as an SSS-symbol bin.

Source files
------------

// File: rtl/ssb_pkg.sv
// Shared constants and state type for SSB resource-element extraction.
package ssb_pkg;

    localparam int SSB_LEN         = 240;
    localparam int SSS_OFFSET      = 56;
    localparam int SSS_LEN         = 127;
    localparam int PBCH_EDGE_LEN   = 48;
    localparam int PBCH_RE_PER_SSB = 576;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SSS_SYM  = 2'd1,
        PBCH_SYM = 2'd2
    } state_t;

endpackage

// File: rtl/axis_fifo.sv
// Synchronous AXI-stream FIFO with a registered head word.
// Push and pop may happen in the same cycle, also when the FIFO is full.
module axis_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [DW-1:0] i_tdata,
    input  logic          i_tvalid,
    output logic          o_full,
    output logic [DW-1:0] o_tdata,
    output logic          o_tvalid,
    input  logic          i_tready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [DW-1:0] r_tdata;
    logic          r_tvalid;

    logic          w_pop;
    logic          w_push;
    logic [AW-1:0] w_rd_nxt;
    logic [CW-1:0] w_remain;
    logic [CW-1:0] w_count_nxt;

    assign o_full      = (r_count == CW'(DEPTH));
    assign w_pop       = r_tvalid & i_tready;
    assign w_push      = i_tvalid & (~o_full | w_pop);
    assign w_rd_nxt    = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;
    // Entries still stored after this cycle's pop, before this cycle's push.
    assign w_remain    = r_count - CW'(w_pop);
    assign w_count_nxt = w_remain + CW'(w_push);

    assign o_tdata  = r_tdata;
    assign o_tvalid = r_tvalid;

    // Storage array: written on every accepted push, no reset needed.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_tdata;
        end
    end

    // Pointers, occupancy and the registered head word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_count_nxt;
            r_tvalid <= (w_count_nxt != '0);
            if (w_remain == '0) begin
                // Empty after the pop: the incoming word (if any) becomes the head.
                if (w_push) begin
                    r_tdata <= i_tdata;
                end
            end else begin
                r_tdata <= r_mem[w_rd_nxt];
            end
        end
    end

endmodule

// File: rtl/ssb_re_extractor.sv
// Maps demodulated FFT bins to SSB roles: SSS bins become hard BPSK bits,
// PBCH bins become saturated LLR pairs queued in a backpressured FIFO.
module ssb_re_extractor
    import ssb_pkg::*;
#(
    parameter int IN_DW      = 32,
    parameter int NFFT       = 8,
    parameter int SSB_START  = 8,
    parameter int LLR_DW     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic [IN_DW-1:0]    s_axis_in_tdata,
    input  logic                s_axis_in_tvalid,
    input  logic                SSS_valid_i,
    input  logic                PBCH_valid_i,
    output logic                m_axis_SSS_tdata,
    output logic                m_axis_SSS_tvalid,
    output logic                SSS_done_o,
    output logic [2*LLR_DW-1:0] m_axis_PBCH_tdata,
    output logic                m_axis_PBCH_tvalid,
    input  logic                m_axis_PBCH_tready,
    output logic                PBCH_done_o,
    output logic                overflow_o,
    output logic                protocol_err_o
);

    localparam int HALF      = IN_DW / 2;
    localparam int LLR_SHIFT = HALF - LLR_DW;
    localparam int KW        = NFFT + 2;
    localparam int SCW       = $clog2(SSS_LEN + 1);
    localparam int PCW       = $clog2(PBCH_RE_PER_SSB);

    localparam logic signed [HALF-1:0] LLR_MAX = HALF'(2 ** (LLR_DW - 1) - 1);
    localparam logic signed [HALF-1:0] LLR_MIN = -LLR_MAX;

    localparam logic signed [KW-1:0] K_ZERO     = '0;
    localparam logic signed [KW-1:0] K_SSS_LO   = KW'(SSS_OFFSET);
    localparam logic signed [KW-1:0] K_SSS_HI   = KW'(SSS_OFFSET + SSS_LEN - 1);
    localparam logic signed [KW-1:0] K_EDGE1_HI = KW'(PBCH_EDGE_LEN - 1);
    localparam logic signed [KW-1:0] K_EDGE2_LO = KW'(SSB_LEN - PBCH_EDGE_LEN);
    localparam logic signed [KW-1:0] K_SSB_HI   = KW'(SSB_LEN - 1);

    // Truncating shift to LLR_DW bits, clamped symmetrically so the most
    // negative code never appears.
    function automatic logic signed [LLR_DW-1:0] f_llr(input logic signed [HALF-1:0] x);
        logic signed [HALF-1:0] v;
        v = x >>> LLR_SHIFT;
        if (v > LLR_MAX) begin
            v = LLR_MAX;
        end else if (v < LLR_MIN) begin
            v = LLR_MIN;
        end
        return v[LLR_DW-1:0];
    endfunction

    state_t            r_state;
    logic [NFFT-1:0]   r_bin_cnt;
    logic [SCW-1:0]    r_sss_cnt;
    logic [PCW-1:0]    r_pbch_cnt;
    logic              r_sss_tdata;
    logic              r_sss_tvalid;
    logic              r_sss_last;
    logic              r_sss_done;
    logic              r_pbch_done;
    logic              r_overflow;
    logic              r_proto_err;

    logic                   w_acc;
    logic                   w_gap;
    logic                   w_is_sss;
    logic                   w_entry;
    logic [NFFT-1:0]        w_bin;
    logic signed [KW-1:0]   w_k;
    logic                   w_in_sss;
    logic                   w_in_edge;
    logic                   w_in_ssb;
    logic                   w_sss_bit;
    logic                   w_pbch_re;
    logic [SCW-1:0]         w_sss_cnt_cur;
    logic signed [HALF-1:0] w_re;
    logic signed [HALF-1:0] w_im;
    logic [2*LLR_DW-1:0]    w_llr_word;
    logic                   w_fifo_full;
    logic                   w_drop;

    assign w_acc    = s_axis_in_tvalid & (SSS_valid_i | PBCH_valid_i);
    assign w_gap    = s_axis_in_tvalid & ~SSS_valid_i & ~PBCH_valid_i;
    // SSS wins when both qualifiers are asserted.
    assign w_is_sss = SSS_valid_i;
    // Fresh symbol: from IDLE, or the qualifier flipped mid-symbol.
    assign w_entry  = w_acc & ((r_state == IDLE) |
                               ((r_state == SSS_SYM) & ~w_is_sss) |
                               ((r_state == PBCH_SYM) & w_is_sss));
    assign w_bin    = w_entry ? '0 : r_bin_cnt;
    assign w_k      = $signed({2'b00, w_bin}) - KW'(SSB_START);

    assign w_in_sss  = (w_k >= K_SSS_LO) && (w_k <= K_SSS_HI);
    assign w_in_edge = ((w_k >= K_ZERO) && (w_k <= K_EDGE1_HI)) ||
                       ((w_k >= K_EDGE2_LO) && (w_k <= K_SSB_HI));
    assign w_in_ssb  = (w_k >= K_ZERO) && (w_k <= K_SSB_HI);

    assign w_sss_bit = w_acc & w_is_sss & w_in_sss;
    assign w_pbch_re = w_acc & (w_is_sss ? w_in_edge : w_in_ssb);

    assign w_sss_cnt_cur = (w_entry & w_is_sss) ? '0 : r_sss_cnt;

    assign w_re       = s_axis_in_tdata[HALF-1:0];
    assign w_im       = s_axis_in_tdata[IN_DW-1:HALF];
    assign w_llr_word = {f_llr(w_im), f_llr(w_re)};
    assign w_drop     = w_pbch_re & w_fifo_full & ~(m_axis_PBCH_tvalid & m_axis_PBCH_tready);

    // Symbol tracker: bin counter and symbol-type state.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state   <= IDLE;
            r_bin_cnt <= '0;
        end else if (w_acc) begin
            r_bin_cnt <= w_bin + NFFT'(1);
            if (&w_bin) begin
                r_state <= IDLE;
            end else begin
                r_state <= w_is_sss ? SSS_SYM : PBCH_SYM;
            end
        end else if (w_gap) begin
            r_bin_cnt <= '0;
            r_state   <= IDLE;
        end
    end

    // SSS hard-decision output, bit counter and completion pulse.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_sss_tdata  <= 1'b0;
            r_sss_tvalid <= 1'b0;
            r_sss_cnt    <= '0;
            r_sss_last   <= 1'b0;
            r_sss_done   <= 1'b0;
        end else begin
            r_sss_tvalid <= w_sss_bit;
            r_sss_tdata  <= w_sss_bit & ~w_re[HALF-1];
            if (w_acc) begin
                r_sss_cnt <= w_sss_cnt_cur + SCW'(w_sss_bit);
            end
            r_sss_last <= w_sss_bit & (w_sss_cnt_cur == SCW'(SSS_LEN - 1));
            r_sss_done <= r_sss_last;
        end
    end

    // PBCH RE accounting plus sticky error flags.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_pbch_cnt  <= '0;
            r_pbch_done <= 1'b0;
            r_overflow  <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_pbch_done <= w_pbch_re & (r_pbch_cnt == PCW'(PBCH_RE_PER_SSB - 1));
            if (w_pbch_re) begin
                r_pbch_cnt <= (r_pbch_cnt == PCW'(PBCH_RE_PER_SSB - 1)) ? '0 : r_pbch_cnt + PCW'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (s_axis_in_tvalid & SSS_valid_i & PBCH_valid_i) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    axis_fifo #(
        .DW    (2 * LLR_DW),
        .DEPTH (FIFO_DEPTH)
    ) u_pbch_fifo (
        .i_clk    (clk_i),
        .i_rst_n  (reset_ni),
        .i_tdata  (w_llr_word),
        .i_tvalid (w_pbch_re),
        .o_full   (w_fifo_full),
        .o_tdata  (m_axis_PBCH_tdata),
        .o_tvalid (m_axis_PBCH_tvalid),
        .i_tready (m_axis_PBCH_tready)
    );

    assign m_axis_SSS_tdata  = r_sss_tdata;
    assign m_axis_SSS_tvalid = r_sss_tvalid;
    assign SSS_done_o        = r_sss_done;
    assign PBCH_done_o       = r_pbch_done;
    assign overflow_o        = r_overflow;
    assign protocol_err_o    = r_proto_err;

endmodule
